// File: rtl/ieee_divider_seq_pkg.sv
// ieee_divider_seq_pkg: shared float defines, divider FSM states and the round-to-nearest-even packer.
`ifndef IEEE_FLOAT_DEFINES
`define IEEE_FLOAT_DEFINES
`define WIDTH_NUMBER 32
`define WIDTH_EXPO 8
`define GUARD_BITS 3
`define WIDTH_SIGNIF (1+23+`GUARD_BITS)
`define ROUND_EVEN 3'b100
`define EXPO_ONES 8'hFF
`define QNAN_CANON 32'h7FC00000
`define DIV_ITER 27
`endif

package ieee_divider_seq_pkg;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    // q carries the hidden bit at the top and GUARD_BITS below the 23-bit fraction.
    function automatic logic [`WIDTH_NUMBER-1:0] round_pack(
        input logic s,
        input logic signed [9:0] e,
        input logic [`WIDTH_SIGNIF-1:0] q,
        input logic sticky
    );
        logic [`GUARD_BITS-1:0] g;
        logic [24:0] m;
        logic signed [9:0] ef;
        logic up;
        g = {q[`GUARD_BITS-1:1], q[0] | sticky};
        up = (g > `ROUND_EVEN) || (g == `ROUND_EVEN && q[`GUARD_BITS]);
        m = {1'b0, q[`WIDTH_SIGNIF-1:`GUARD_BITS]} + {24'd0, up};
        ef = e + (m[24] ? 10'sd1 : 10'sd0);
        return (ef >= 10'sd255) ? {s, `EXPO_ONES, 23'd0} :
               (ef <= 10'sd0)   ? {s, 31'd0} :
                                  {s, ef[7:0], m[24] ? m[23:1] : m[22:0]};
    endfunction

endpackage

// File: rtl/ieee_divider_seq_if.sv
// ieee_divider_seq_if: operand/result valid-ready bus of the sequential divider.
interface ieee_divider_seq_if;
    logic                     in_valid;
    logic                     in_ready;
    logic [`WIDTH_NUMBER-1:0] operand_a;
    logic [`WIDTH_NUMBER-1:0] operand_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [`WIDTH_NUMBER-1:0] result;
    logic                     div_by_zero;
    logic                     invalid;
    modport master (
        output in_valid, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, div_by_zero, invalid
    );
    modport slave (
        input  in_valid, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, div_by_zero, invalid
    );
endinterface

// File: rtl/ieee_div_classify.sv
// ieee_div_classify: unpacks divider operands and decodes zero/inf special-case results.
// IEEE_DIV_SPECIAL_EN adds NaN propagation and invalid detection for 0/0 and inf/inf.
module ieee_div_classify
    import ieee_divider_seq_pkg::*;
(
    input  logic [`WIDTH_NUMBER-1:0] a,
    input  logic [`WIDTH_NUMBER-1:0] b,
    output logic [23:0]              ma,
    output logic [23:0]              mb,
    output logic                     special,
    output logic                     dbz,
    output logic                     inv,
    output logic [`WIDTH_NUMBER-1:0] res
);
    logic sign, a_zero, b_zero, a_inf, b_inf, nan;
    assign sign   = a[31] ^ b[31];
    assign a_zero = a[30:23] == '0;
    assign b_zero = b[30:23] == '0;
    assign a_inf  = a[30:23] == `EXPO_ONES;
    assign b_inf  = b[30:23] == `EXPO_ONES;
    assign ma     = {1'b1, a[22:0]};
    assign mb     = {1'b1, b[22:0]};
`ifdef IEEE_DIV_SPECIAL_EN
    assign nan = (a_inf && |a[22:0]) || (b_inf && |b[22:0]) || (a_zero && b_zero) || (a_inf && b_inf);
`else
    assign nan = 1'b0;
`endif
    assign special = a_zero | b_zero | a_inf | b_inf;
    assign dbz     = b_zero & ~a_zero & ~a_inf & ~nan;
    assign inv     = nan;
    // inf/anything and finite-nonzero/0 give infinity; every other special is a signed zero
    assign res = nan ? `QNAN_CANON :
                 (a_inf | (b_zero & ~a_zero)) ? {sign, `EXPO_ONES, 23'd0} : {sign, 31'd0};
endmodule

// File: rtl/ieee_divider_seq.sv
// ieee_divider_seq: iterative IEEE-754 single divider, restoring, one quotient bit per clock, RNE.
// Build with IEEE_DIV_SPECIAL_EN for NaN results and the invalid flag.
module ieee_divider_seq
    import ieee_divider_seq_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    ieee_divider_seq_if.slave bus
);
    state_t state, state_n;
    logic [4:0] cnt;
    logic sign, dbz, inv, special, c_dbz, c_inv, pre, q_bit, accept;
    logic signed [9:0] expo;
    logic [23:0] ma, mb, div, rem_sub;
    logic [24:0] rem;
    logic [`WIDTH_SIGNIF-1:0] quo;
    logic [`WIDTH_NUMBER-1:0] result, c_res;

    ieee_div_classify u_classify (
        .a(bus.operand_a), .b(bus.operand_b), .ma(ma), .mb(mb),
        .special(special), .dbz(c_dbz), .inv(c_inv), .res(c_res)
    );

    assign accept  = state == IDLE && bus.in_valid;
    assign pre     = ma < mb;
    assign q_bit   = rem >= {1'b0, div};
    // remainder after a successful subtract is below the divisor, so 24 bits hold it
    assign rem_sub = q_bit ? 24'(rem - {1'b0, div}) : rem[23:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = (state == IDLE)  ? (bus.in_valid ? (special ? DONE : DIV) : IDLE) :
                  (state == DIV)   ? ((cnt == 5'(`DIV_ITER - 1)) ? ROUND : DIV) :
                  (state == ROUND) ? DONE :
                                     (bus.out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sign   <= 1'b0;
            expo   <= '0;
            div    <= '0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
            dbz    <= 1'b0;
            inv    <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            sign   <= bus.operand_a[31] ^ bus.operand_b[31];
            expo   <= {2'b0, bus.operand_a[30:23]} - {2'b0, bus.operand_b[30:23]} + 10'd127 - {9'd0, pre};
            div    <= mb;
            rem    <= pre ? {ma, 1'b0} : {1'b0, ma};
            quo    <= '0;
            result <= special ? c_res : result;
            dbz    <= c_dbz;
            inv    <= c_inv;
        end else if (state == DIV) begin
            cnt <= cnt + 5'd1;
            rem <= {rem_sub, 1'b0};
            quo <= {quo[`WIDTH_SIGNIF-2:0], q_bit};
        end else if (state == ROUND) begin
            result <= round_pack(sign, expo, quo, |rem);
        end
    end

    assign bus.in_ready    = state == IDLE;
    assign bus.out_valid   = state == DONE;
    assign bus.result      = result;
    assign bus.div_by_zero = dbz;
    assign bus.invalid     = inv;
endmodule

// File: tb/tb_ieee_divider_seq.sv
// tb_ieee_divider_seq: directed and random checks of ieee_divider_seq against an exact-integer RNE model.
module tb_ieee_divider_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    ieee_divider_seq_if bus();
    ieee_divider_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Exact quotient by integer division, then true round-to-nearest-even on the 24-bit significand.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic d, output logic iv, output int lat);
        logic s, az, bz, ai, bi;
        int e, sh;
        longint unsigned num, q, rm, rb, half, mant, den;
        s = a[31] ^ b[31];
        az = a[30:23] == 8'd0;
        bz = b[30:23] == 8'd0;
        ai = a[30:23] == 8'hFF;
        bi = b[30:23] == 8'hFF;
        d = 1'b0;
        iv = 1'b0;
        lat = 1;
`ifdef IEEE_DIV_SPECIAL_EN
        if ((ai && a[22:0] != 0) || (bi && b[22:0] != 0) || (az && bz) || (ai && bi)) begin
            r = 32'h7FC00000;
            iv = 1'b1;
            return;
        end
`endif
        if (ai) begin
            r = {s, 8'hFF, 23'd0};
            return;
        end
        if (az || bi) begin
            r = {s, 31'd0};
            return;
        end
        if (bz) begin
            r = {s, 8'hFF, 23'd0};
            d = 1'b1;
            return;
        end
        lat = 29;
        num = longint'({1'b1, a[22:0]}) << 40;
        den = longint'({1'b1, b[22:0]});
        q = num / den;
        rm = num % den;
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q >= (64'd1 << 40)) sh = 17;
        else begin
            sh = 16;
            e--;
        end
        mant = q >> sh;
        rb = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rb > half || (rb == half && (rm != 0 || mant[0]))) mant++;
        if (mant == (64'd1 << 24)) e++;
        if (e >= 255) r = {s, 8'hFF, 23'd0};
        else if (e <= 0) r = {s, 31'd0};
        else r = {s, 8'(e), 23'(mant)};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 9);
        v[30:23] = (k == 0) ? 8'd0 : (k == 1) ? 8'hFF : (k == 2) ? v[30:23] : 8'($urandom_range(100, 154));
        return v;
    endfunction

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ed, input logic ei, input int lat);
        int n;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            n++;
        end while (!bus.out_valid && n < 60);
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " result"}, bus.result, er);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(ed));
        check({tag, " invalid"}, 32'(bus.invalid), 32'(ei));
        @(posedge clk);
        #1;
        check({tag, " release"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, er;
        logic ed, ei;
        int lat, n;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        check("reset invalid", 32'(bus.invalid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 29);
        op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 29);
        op("div_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 1);
        op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b0, 29);
        op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 29);
        op("denorm_flush", 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1);
        op("inf_by_zero", 32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b0, 1);
        op("x_by_inf", 32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1);
`ifdef IEEE_DIV_SPECIAL_EN
        op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1);
        op("zero_by_zero", 32'h80000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1);
        op("inf_by_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 1);
`else
        op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0, 1);
        op("zero_by_zero", 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1);
        op("inf_by_inf", 32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0, 1);
`endif
        // backpressure: result held for five cycles with out_ready low
        bus.operand_a = 32'h40C00000;
        bus.operand_b = 32'h40000000;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            n++;
        end while (!bus.out_valid && n < 60);
        check("bp latency", 32'(n), 32'd29);
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp result", bus.result, 32'h40400000);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp drained", 32'(bus.out_valid), 32'd0);
        check("bp in_ready back", 32'(bus.in_ready), 32'd1);
        // reset during the tenth division cycle
        bus.operand_a = 32'h3F800000;
        bus.operand_b = 32'h40400000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst result", bus.result, 32'd0);
        check("rst div_by_zero", 32'(bus.div_by_zero), 32'd0);
        check("rst invalid", 32'(bus.invalid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op("after_reset", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 29);
        for (int i = 0; i < 40; i++) begin
            a = rnd_op();
            b = rnd_op();
            model(a, b, er, ed, ei, lat);
            op($sformatf("rand%0d_%h_%h", i, a, b), a, b, er, ed, ei, lat);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ieee_divider_seq.md
Name: ieee_divider_seq

Overview:
- Iterative single-precision IEEE-754 divider: result = operand_a / operand_b.
- Complements the combinational adder/subtractor in the float datapath.
- Uses valid/ready handshakes on both sides and one quotient bit per clock (restoring division).
- Reuses the adder's operand format (hidden bit plus `GUARD_BITS) and its round-to-nearest-even rule.

Parameters:
- None. All widths come from the shared defines (`WIDTH_NUMBER=32b, `WIDTH_EXPO=8b, `WIDTH_SIGNIF=1+23+`GUARD_BITS, `GUARD_BITS=3).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  high only in IDLE
- operand_a  in  `WIDTH_NUMBER  dividend
- operand_b  in  `WIDTH_NUMBER  divisor
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  `WIDTH_NUMBER  quotient
- div_by_zero  out  1  finite nonzero / zero; qualified by out_valid
- invalid  out  1  NaN result; tied 0 unless the optional feature is compiled in

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous active-low.
  - Reset forces state=IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0, invalid=0.
  - Reset mid-operation discards the operation; no output is produced for it.
- States: IDLE, DIV, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, register the unpacked operands: signs, exponents, 24-bit significands with the hidden bit.
  - Inputs with exponent 0 are flushed to zero (denormals not supported).
  - Special cases go IDLE->DONE directly. out_valid rises at the 1st edge after acceptance.
    - x/0 (x finite nonzero): signed infinity, div_by_zero=1.
    - 0/x: signed zero.
    - inf/x (x finite): signed infinity.
    - x/inf: signed zero.
    - 0/0: signed zero. inf/inf: signed infinity.
    - Exponent 255 is treated as infinity regardless of fraction.
  - Normal case goes to DIV.
    - sign = sa^sb.
    - exp = ea - eb + 127, held as a 10-bit signed value.
    - If ma<mb: pre-shift the remainder left 1 and decrement exp.
- DIV:
  - Exactly 27 cycles (24 significand bits + `GUARD_BITS), driven by a 5-bit counter.
  - Each cycle: trial-subtract the divisor from the remainder, shift in one quotient bit, shift the remainder left.
  - Quotient MSB is always 1.
- ROUND:
  - 1 cycle. Sticky = (final remainder != 0), ORed into the LSB guard bit.
  - Round to nearest even using the same comparison as the adder (guard > `ROUND_EVEN, or == with LSB=1).
  - If rounding carries out of the significand, increment exp.
  - exp >= 255: signed infinity (0x7F800000 | sign).
  - exp <= 0: signed zero (flush).
  - Otherwise pack {sign, exp[7:0], frac23}.
- DONE:
  - out_valid=1. result and flags stay stable until out_ready.
  - On out_valid & out_ready, go to IDLE. in_ready returns on the next cycle; there is no same-cycle bypass.
- Latency:
  - Normal: accept at edge k; DIV occupies k+1..k+27; ROUND at k+28; out_valid high after edge k+29.
  - Special: out_valid high after edge k+1.
- Throughput: one operation in flight. in_valid is ignored outside IDLE.

Optional Feature:
- Macro: IEEE_DIV_SPECIAL_EN.
- Defined:
  - A NaN operand (exponent 255, fraction != 0), 0/0 or inf/inf returns canonical qNaN 0x7FC00000 with invalid=1.
  - NaN operands take priority over the divide-by-zero rule.
- Undefined:
  - Behaviour exactly as in Behaviour. invalid is tied 0.

Decomposition:
- Shared defines:
  - Width macros, `GUARD_BITS, `ROUND_EVEN, `EXPO_ONES.
  - New: `QNAN_CANON=32'h7FC00000 and `DIV_ITER=27.
- Reuse the existing rounding module in ROUND.
- One new sub-module, ieee_div_classify: combinational zero/inf/NaN/special-result decode, shared by the FSM.

Test Plan:
- 6.0/2.0: 0x40C00000 / 0x40000000 -> 0x40400000. out_valid exactly 29 cycles after accept.
- 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB. Exercises sticky and round-up.
- Divide by zero: 0xBF800000 / 0x00000000 -> 0xFF800000, div_by_zero=1, out_valid 1 cycle after accept.
- Overflow/underflow:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000.
  - 0x00800000 / 0x40000000 -> 0x00000000.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: result and out_valid are stable, and in_ready=0 throughout.
  - Assert rst_n=0 during DIV cycle 10: all outputs 0 immediately, and the next operation completes correctly.
- With IEEE_DIV_SPECIAL_EN: 0x7FC00001 / 0x3F800000 -> 0x7FC00000, invalid=1. Without the macro, the same stimulus -> 0x7F800000, invalid=0.
